// File: rtl/lo_nco.sv
// Quadrature LO generator: phase accumulator feeding a time-shared quarter-wave sine ROM.
// One sample per 4 clocks. Optional NCO_DITHER_EN adds LFSR dither ahead of phase truncation.
//
// state   | meaning
// S_PH    | advance accumulator, latch lookup phase
// S_SIN   | ROM address <= sin(ph)
// S_COS   | capture sin, ROM address <= cos(ph)
// S_OUT   | capture cos, present lo_i/lo_q, raise lo_valid
module lo_nco #(
  parameter int PSZ = 32,
  parameter int LSZ = 10,
  parameter int DSZ = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PSZ-1:0]        freq_word,
  input  logic                  freq_load,
  input  logic                  phase_rst,
  output logic signed [DSZ-1:0] lo_i,
  output logic signed [DSZ-1:0] lo_q,
  output logic                  lo_valid
);

  localparam int  AW   = LSZ - 2;
  localparam int  ROMN = 2 ** AW;
  localparam real AMP  = real'(2 ** (DSZ - 1) - 1);
  localparam real PI   = 3.14159265358979323846;

  typedef enum logic [1:0] {
    S_PH  = 2'd0,
    S_SIN = 2'd1,
    S_COS = 2'd2,
    S_OUT = 2'd3
  } slot_t;

  // Half-step sample offset makes T[~idx] an exact mirror of T[idx].
  logic signed [DSZ-1:0] rom [ROMN];
  for (genvar k = 0; k < ROMN; k++) begin : g_rom
    localparam real ANG = 2.0 * PI * (real'(k) + 0.5) / real'(2 ** LSZ);
    localparam int  VAL = int'(AMP * $sin(ANG));
    assign rom[k] = DSZ'(VAL);
  end

  slot_t                 cnt;
  logic [PSZ-1:0]        acc;
  logic [PSZ-1:0]        inc;
  logic [LSZ-1:0]        ph;
  logic                  pending;
  logic [AW-1:0]         rom_addr;
  logic                  rom_neg;
  logic signed [DSZ-1:0] rom_q;
  logic signed [DSZ-1:0] rom_val;
  logic signed [DSZ-1:0] sin_r;
  logic [LSZ-1:0]        ph_next;

  // {negate, address} for the sine of phase p
  function automatic logic [AW:0] lut_addr(input logic [LSZ-1:0] p);
    logic [AW-1:0] idx;
    idx = p[AW-1:0];
    return {p[LSZ-1], (p[LSZ-2] ? ~idx : idx)};
  endfunction

  assign rom_q   = rom[rom_addr];
  assign rom_val = rom_neg ? -rom_q : rom_q;

`ifdef NCO_DITHER_EN
  logic [31:0]      lfsr;
  logic [31:0]      lfsr_next;
  logic [PSZ-LSZ:0] dith_sum;
  logic             unused_dith;

  assign lfsr_next   = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
  assign dith_sum    = {1'b0, acc[PSZ-LSZ-1:0]} + {1'b0, lfsr[PSZ-LSZ-1:0]};
  assign ph_next     = acc[PSZ-1:PSZ-LSZ] + {{(LSZ-1){1'b0}}, dith_sum[PSZ-LSZ]};
  assign unused_dith = ^dith_sum[PSZ-LSZ-1:0];

  always_ff @(posedge clk) begin
    if (reset)
      lfsr <= 32'hACE1_2345;
    else if (cnt == S_PH)
      lfsr <= lfsr_next;
  end
`else
  assign ph_next = acc[PSZ-1:PSZ-LSZ];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= S_PH;
      acc      <= '0;
      inc      <= '0;
      ph       <= '0;
      pending  <= 1'b0;
      rom_addr <= '0;
      rom_neg  <= 1'b0;
      sin_r    <= '0;
      lo_i     <= '0;
      lo_q     <= '0;
      lo_valid <= 1'b0;
    end else begin
      lo_valid <= 1'b0;
      if (freq_load)
        inc <= freq_word;
      if (phase_rst)
        pending <= 1'b1;
      case (cnt)
        S_PH: begin
          cnt <= S_SIN;
          // acc reads inc before any same-edge load lands
          if (pending || phase_rst) begin
            ph      <= '0;
            acc     <= inc;
            pending <= 1'b0;
          end else begin
            ph  <= ph_next;
            acc <= acc + inc;
          end
        end
        S_SIN: begin
          cnt                 <= S_COS;
          {rom_neg, rom_addr} <= lut_addr(ph);
        end
        S_COS: begin
          cnt                 <= S_OUT;
          sin_r               <= rom_val;
          {rom_neg, rom_addr} <= lut_addr(ph + LSZ'(ROMN));
        end
        S_OUT: begin
          cnt      <= S_PH;
          lo_q     <= sin_r;
          lo_i     <= rom_val;
          lo_valid <= 1'b1;
        end
        default: cnt <= S_PH;
      endcase
    end
  end

endmodule

// File: tb/tb_lo_nco.sv
// Directed self-checking bench for lo_nco; expected LO pairs are hand-derived from the ROM formula.
// Build with NCO_DITHER_EN defined to exercise the dithered phase path.
module tb_lo_nco;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [31:0]        freq_word = '0;
  logic               freq_load = 1'b0;
  logic               phase_rst = 1'b0;
  logic signed [15:0] lo_i;
  logic signed [15:0] lo_q;
  logic               lo_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // (lo_i, lo_q) for phases 0, 256, 512, 768
  logic signed [15:0] qi [4] = '{16'sd32767, -16'sd101, -16'sd32767, 16'sd101};
  logic signed [15:0] qq [4] = '{16'sd101, 16'sd32767, -16'sd101, -16'sd32767};
  logic signed [15:0] si [1024];
  logic signed [15:0] co [1024];

  lo_nco dut (
    .clk      (clk),
    .reset    (reset),
    .freq_word(freq_word),
    .freq_load(freq_load),
    .phase_rst(phase_rst),
    .lo_i     (lo_i),
    .lo_q     (lo_q),
    .lo_valid (lo_valid)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset, then load fw in the first slot-0 cycle; returns in cycle 1 after release.
  task automatic restart(input logic [31:0] fw);
    reset = 1'b1; freq_load = 1'b0; phase_rst = 1'b0;
    tick(3);
    reset = 1'b0; freq_word = fw; freq_load = 1'b1;
    tick();
    freq_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    n_checks++;
    if (lo_i !== 16'sd0 || lo_q !== 16'sd0 || lo_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got i=%0d q=%0d v=%0b, expected 0 0 0", lo_i, lo_q, lo_valid);
    end
    reset = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c % 4 == 0) begin
        n_checks++;
        if (lo_valid !== 1'b1 || lo_i !== 16'sd32767 || lo_q !== 16'sd101) begin
          n_fail++;
          $display("FAIL reset_first_pair cyc%0d: got v=%0b i=%0d q=%0d, expected 1 32767 101",
                   c, lo_valid, lo_i, lo_q);
        end
      end else begin
        n_checks++;
        if (lo_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_valid_low cyc%0d: got %0b, expected 0", c, lo_valid);
        end
      end
    end
  endtask

  task automatic test_quadrature();
    int k, q;
    restart(32'h4000_0000);
    for (int c = 2; c <= 40; c++) begin
      tick();
      if (c % 4 == 0) begin
        k = c / 4 - 1;
        q = (k == 0) ? 0 : (k - 1) % 4;
        n_checks++;
        if (lo_valid !== 1'b1 || lo_i !== qi[q] || lo_q !== qq[q]) begin
          n_fail++;
          $display("FAIL quad_pair k%0d: got v=%0b i=%0d q=%0d, expected 1 %0d %0d",
                   k, lo_valid, lo_i, lo_q, qi[q], qq[q]);
        end
      end else begin
        n_checks++;
        if (lo_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL quad_spacing cyc%0d: got valid %0b, expected 0", c, lo_valid);
        end
      end
    end
  endtask

  task automatic test_sweep();
    longint e;
    longint full = 64'd1073676289;
    restart(32'h0040_0000);
    tick(3);
    for (int k = 1; k <= 1024; k++) begin
      tick(4);
      n_checks++;
      if (lo_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL sweep_valid k%0d: got %0b, expected 1", k, lo_valid);
      end
      si[k-1] = lo_q;
      co[k-1] = lo_i;
    end
    n_checks++;
    if (co[0] !== 16'sd32767 || si[0] !== 16'sd101) begin
      n_fail++;
      $display("FAIL sweep_ph0: got i=%0d q=%0d, expected 32767 101", co[0], si[0]);
    end
    n_checks++;
    if (co[1] !== 16'sd32766 || si[1] !== 16'sd302) begin
      n_fail++;
      $display("FAIL sweep_ph1: got i=%0d q=%0d, expected 32766 302", co[1], si[1]);
    end
    for (int p = 0; p < 1024; p++) begin
      e = longint'(si[p]) * si[p] + longint'(co[p]) * co[p];
      n_checks++;
      if (e > full + full / 100 || e < full - full / 100) begin
        n_fail++;
        $display("FAIL sweep_energy p%0d: got %0d, expected within 1%% of %0d", p, e, full);
      end
      n_checks++;
      if (si[p] === -16'sd32768 || co[p] === -16'sd32768) begin
        n_fail++;
        $display("FAIL sweep_minval p%0d: got i=%0d q=%0d, expected neither -32768", p, co[p], si[p]);
      end
      n_checks++;
      if (co[p] !== si[(p + 256) % 1024]) begin
        n_fail++;
        $display("FAIL sweep_cos_offset p%0d: got %0d, expected %0d", p, co[p], si[(p + 256) % 1024]);
      end
    end
    // strictly rising first quadrant means all 256 entries were distinct and visited
    for (int p = 1; p < 256; p++) begin
      n_checks++;
      if (!(si[p] > si[p-1])) begin
        n_fail++;
        $display("FAIL sweep_monotonic p%0d: got %0d after %0d, expected larger", p, si[p], si[p-1]);
      end
    end
    for (int p = 0; p < 512; p++) begin
      n_checks++;
      if (si[p+512] !== -si[p] || si[511-p] !== si[p]) begin
        n_fail++;
        $display("FAIL sweep_symmetry p%0d: got %0d/%0d, expected %0d/%0d",
                 p, si[p+512], si[511-p], -si[p], si[p]);
      end
    end
  endtask

  task automatic test_phase_rst(input int s, input bit with_load);
    int m, cyc, q2, q3;
    restart(32'h4000_0000);
    tick(19 + s);
    phase_rst = 1'b1;
    if (with_load) begin
      freq_word = 32'h8000_0000;
      freq_load = 1'b1;
    end
    tick();
    phase_rst = 1'b0;
    freq_load = 1'b0;
    cyc = 21 + s;
    m = (s == 0) ? 5 : 6;
    tick(4 * m + 4 - cyc);
    n_checks++;
    if (lo_valid !== 1'b1 || lo_i !== 16'sd32767 || lo_q !== 16'sd101) begin
      n_fail++;
      $display("FAIL prst_zero slot%0d: got v=%0b i=%0d q=%0d, expected 1 32767 101",
               s, lo_valid, lo_i, lo_q);
    end
    q2 = 1;
    q3 = with_load ? 3 : 2;
    tick(4);
    n_checks++;
    if (lo_valid !== 1'b1 || lo_i !== qi[q2] || lo_q !== qq[q2]) begin
      n_fail++;
      $display("FAIL prst_next slot%0d: got v=%0b i=%0d q=%0d, expected 1 %0d %0d",
               s, lo_valid, lo_i, lo_q, qi[q2], qq[q2]);
    end
    tick(4);
    n_checks++;
    if (lo_valid !== 1'b1 || lo_i !== qi[q3] || lo_q !== qq[q3]) begin
      n_fail++;
      $display("FAIL prst_after slot%0d load%0b: got i=%0d q=%0d, expected %0d %0d",
               s, with_load, lo_i, lo_q, qi[q3], qq[q3]);
    end
  endtask

  task automatic test_reset_midslot();
    restart(32'h4000_0000);
    tick(9);
    reset = 1'b1;
    tick();
    n_checks++;
    if (lo_i !== 16'sd0 || lo_q !== 16'sd0 || lo_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midslot_clear: got i=%0d q=%0d v=%0b, expected 0 0 0", lo_i, lo_q, lo_valid);
    end
    tick();
    reset = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      n_checks++;
      if (c % 4 == 0) begin
        if (lo_valid !== 1'b1 || lo_i !== 16'sd32767 || lo_q !== 16'sd101) begin
          n_fail++;
          $display("FAIL midslot_restart cyc%0d: got v=%0b i=%0d q=%0d, expected 1 32767 101",
                   c, lo_valid, lo_i, lo_q);
        end
      end else if (lo_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midslot_valid cyc%0d: got %0b, expected 0", c, lo_valid);
      end
    end
  endtask

  task automatic test_slow_freq();
    int differ;
    restart(32'h0000_0000);
    tick(3);
    for (int k = 1; k <= 32; k++) begin
      tick(4);
      n_checks++;
      if (lo_valid !== 1'b1 || lo_i !== 16'sd32767 || lo_q !== 16'sd101) begin
        n_fail++;
        $display("FAIL zero_freq k%0d: got v=%0b i=%0d q=%0d, expected 1 32767 101",
                 k, lo_valid, lo_i, lo_q);
      end
    end
    restart(32'h0000_1000);
    tick(3);
    differ = 0;
    for (int k = 1; k <= 1024; k++) begin
      tick(4);
      if (lo_i !== 16'sd32767 || lo_q !== 16'sd101)
        differ++;
`ifndef NCO_DITHER_EN
      n_checks++;
      if (lo_i !== 16'sd32767 || lo_q !== 16'sd101) begin
        n_fail++;
        $display("FAIL slow_trunc k%0d: got i=%0d q=%0d, expected 32767 101", k, lo_i, lo_q);
      end
`endif
    end
`ifdef NCO_DITHER_EN
    n_checks++;
    if (differ == 0) begin
      n_fail++;
      $display("FAIL dither_spread: got %0d differing samples, expected at least 1", differ);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_quadrature();
    test_sweep();
    for (int s = 0; s < 4; s++)
      test_phase_rst(s, 1'b0);
    test_phase_rst(0, 1'b1);
    test_reset_midslot();
    test_slow_freq();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lo_nco.md
Name: lo_nco

Overview:
Numerically controlled oscillator that generates the quadrature local-oscillator pair consumed by the complex mixer's lo_i/lo_q inputs.
- Sample rate is clk/4, matching the mixer's 4-cycle schedule.
- A single quarter-wave sine ROM is time-shared across the 4-cycle slot to produce both sin and cos.
- Frequency is runtime-programmable; phase reset is synchronous.

Parameters:
PSZ, 32, phase accumulator width (bits)
LSZ, 10, phase bits used for lookup (full cycle = 2^LSZ points; ROM holds 2^(LSZ-2) entries)
DSZ, 16, output word size (signed)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
freq_word  input  PSZ  phase increment per output sample (unsigned)
freq_load  input  1  one-cycle strobe; captures freq_word
phase_rst  input  1  one-cycle strobe; restarts phase at 0
lo_i  output  DSZ  cosine output (signed)
lo_q  output  DSZ  sine output (signed)
lo_valid  output  1  one-cycle pulse marking a new lo_i/lo_q pair

Behaviour:
- Reset clears slot counter cnt, accumulator acc, increment register inc, lookup phase ph, pending flag, and lo_i, lo_q, lo_valid to 0.
- cnt is 2 bits, free-running 0->1->2->3->0 and starting at 0 on the first cycle after reset.
- ROM: T[k] = round((2^(DSZ-1)-1) * sin(2*pi*(k+0.5)/2^LSZ)), k = 0..2^(LSZ-2)-1, built at elaboration. The half-step offset makes the symmetry exact. Max magnitude is 2^(DSZ-1)-1, so negation never overflows.
- Lookup of phase p (LSZ bits):
  - quadrant = p[LSZ-1:LSZ-2], idx = p[LSZ-3:0].
  - sin(p): Q0 = T[idx]; Q1 = T[~idx]; Q2 = -T[idx]; Q3 = -T[~idx].
  - cos(p) = sin(p + 2^(LSZ-2)), modulo 2^LSZ.
- cnt==0:
  - With phase_rst pending: ph <= 0, acc <= inc, clear pending.
  - Otherwise: ph <= acc[PSZ-1:PSZ-LSZ], acc <= acc + inc (wraps modulo 2^PSZ).
- cnt==1: ROM address <= sin address of ph (registered ROM read).
- cnt==2: capture sin result; ROM address <= cos address.
- cnt==3: capture cos result. On this clock edge lo_q <= sin, lo_i <= cos, lo_valid <= 1.
- lo_valid is high only during the cycle cnt==0. Outputs hold their values between updates.
- Latency: the phase sampled at a cnt==0 edge appears on the outputs 4 clocks later. The first valid pair after reset is the phase-0 sample.
- freq_load: inc <= freq_word on the same edge, in any slot. A load coinciding with cnt==0 does not affect that cycle's accumulation, which uses the old inc. The new inc first applies at the following cnt==0.
- phase_rst: sets pending on any cycle and is consumed at the next cnt==0. A strobe arriving during cnt==0 is consumed immediately.
- Simultaneous freq_load and phase_rst at cnt==0: ph <= 0, acc <= old inc.
- Reset mid-slot: everything returns to reset values at once; no partial sample is emitted.

Optional Feature:
NCO_DITHER_EN
- Defined: a 32-bit Galois LFSR (taps 32,22,2,1; seed 0xACE1_2345 on reset) advances once per sample. Its low PSZ-LSZ bits are added to acc before truncation to ph, and the carry into the top LSZ bits is honoured. This spreads truncation spurs into noise. acc itself is never dithered.
- Undefined: plain truncation. No LFSR logic is synthesised.

Test Plan:
- Reset release, freq_word=0 never loaded -> first lo_valid 4 clocks after reset deassertion with lo_i=32767, lo_q=101; identical pair every 4 clocks thereafter.
- freq_load with freq_word=0x4000_0000 -> (lo_i, lo_q) sequence (32767,101), (-101,32767), (-32767,-101), (101,-32767), repeating. lo_valid spacing exactly 4 clocks.
- freq_word=0x0040_0000 (1 LUT step per sample) for 1024 samples -> every ROM entry is visited; lo_i^2 + lo_q^2 stays within 1% of 32767^2; no output equals -32768.
- Mid-run phase_rst in each of the 4 slots -> the next pair is (32767,101), followed by the pair for phase = inc. A freq_load in the same cycle follows the old-inc rule above.
- reset asserted during cnt==2 -> outputs 0 on the next cycle; restart behaves as the first scenario.
- NCO_DITHER_EN defined, freq_word=0 -> outputs stay (32767,101), since dither cannot carry out of zero phase. With freq_word=0x0000_1000, the lower 22 bits vary and the sequence differs from the non-dither build within 2^22/0x1000 samples.
